alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared combinational ALU: one operation in flight.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default build uses fixed priority (req0 wins).
module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_src1,
    input  logic [31:0] req0_src2,
    input  logic [5:0]  req0_funct,
    input  logic [4:0]  req0_shamt,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_src1,
    input  logic [31:0] req1_src2,
    input  logic [5:0]  req1_funct,
    input  logic [4:0]  req1_shamt,

    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [5:0]  alu_funct,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_carry,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   grant_any;
    logic   grant_sel;
    logic   grant_id;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic   last_grant;
`endif

    // grant_sel is the index that would win if a grant happened this cycle
    always_comb begin
        grant_any = req0_valid | req1_valid;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (req0_valid && req1_valid)
            grant_sel = ~last_grant;
        else
            grant_sel = ~req0_valid;
`else
        grant_sel = ~req0_valid;
`endif
    end

    // Ready is the accept strobe of the IDLE cycle; gated by rst_n so it is low throughout reset
    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant_sel;
    assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
            alu_src1   <= 32'd0;
            alu_src2   <= 32'd0;
            alu_funct  <= 6'd0;
            alu_shamt  <= 5'd0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 32'd0;
            rsp_zero   <= 1'b0;
            rsp_carry  <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        if (grant_sel) begin
                            alu_src1  <= req1_src1;
                            alu_src2  <= req1_src2;
                            alu_funct <= req1_funct;
                            alu_shamt <= req1_shamt;
                        end else begin
                            alu_src1  <= req0_src1;
                            alu_src2  <= req0_src2;
                            alu_funct <= req0_funct;
                            alu_shamt <= req0_shamt;
                        end
                        grant_id <= grant_sel;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        last_grant <= grant_sel;
`endif
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_carry  <= alu_carry;
                    rsp_id     <= grant_id;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU; follows ALU_ARB_ROUND_ROBIN_EN when defined.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic [5:0]  req0_funct, req1_funct;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [5:0]  alu_funct;
    logic [4:0]  alu_shamt;
    logic        alu_zero, alu_carry;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry;
    logic [31:0] rsp_result;

    int checks_total  = 0;
    int checks_passed = 0;

    localparam logic [5:0] F_ADD = 6'b001001;
    localparam logic [5:0] F_SUB = 6'b001010;
    localparam logic [5:0] F_AND = 6'b010001;
    localparam logic [5:0] F_SRL = 6'b100010;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req0_funct(req0_funct), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_src1(req1_src1), .req1_src2(req1_src2),
        .req1_funct(req1_funct), .req1_shamt(req1_shamt),
        .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_funct(alu_funct), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry)
    );

    // Shared ALU model; zero reports operand equality, carry is carry-out on add and borrow on sub
    always_comb begin
        alu_result = 32'd0;
        alu_carry  = 1'b0;
        case (alu_funct)
            F_ADD: {alu_carry, alu_result} = {1'b0, alu_src1} + {1'b0, alu_src2};
            F_SUB: begin
                alu_result = alu_src1 - alu_src2;
                alu_carry  = (alu_src1 < alu_src2);
            end
            F_AND: alu_result = alu_src1 & alu_src2;
            F_SRL: alu_result = alu_src1 >> alu_shamt;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_src1 == alu_src2);
    end

    task automatic applyStimulus(input int id, input logic v, input logic [31:0] s1,
                                 input logic [31:0] s2, input logic [5:0] f, input logic [4:0] sh);
        if (id == 0) begin
            req0_valid = v; req0_src1 = s1; req0_src2 = s2; req0_funct = f; req0_shamt = sh;
        end else begin
            req1_valid = v; req1_src1 = s1; req1_src2 = s2; req1_funct = f; req1_shamt = sh;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic exp_grant [4];
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

        // Reset with both requesters pushing: nothing may be accepted or latched
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        applyStimulus(0, 1'b1, 32'hDEADBEEF, 32'h12345678, F_ADD, 5'd7);
        applyStimulus(1, 1'b1, 32'hCAFEF00D, 32'h87654321, F_SUB, 5'd3);
        @(negedge clk); @(negedge clk); #1;
        checkOutput("reset_req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("reset_req1_ready", 32'(req1_ready), 32'd0);
        checkOutput("reset_rsp_valid",  32'(rsp_valid),  32'd0);
        checkOutput("reset_rsp_result", rsp_result,      32'd0);
        checkOutput("reset_alu_src1",   alu_src1,        32'd0);
        checkOutput("reset_alu_funct",  32'(alu_funct),  32'd0);
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        rst_n = 1'b1;
        tick();

        // Single op: req0 add with carry-out
        applyStimulus(0, 1'b1, 32'hFFFFFFFF, 32'h00000001, F_ADD, 5'd0);
        #1;
        checkOutput("add_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("add_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        #1;
        checkOutput("add_exec_ready",   32'(req0_ready), 32'd0);
        checkOutput("add_exec_valid",   32'(rsp_valid),  32'd0);
        checkOutput("add_alu_src1",     alu_src1,        32'hFFFFFFFF);
        checkOutput("add_alu_src2",     alu_src2,        32'h00000001);
        checkOutput("add_alu_funct",    32'(alu_funct),  32'(F_ADD));
        tick();
        checkOutput("add_rsp_valid",    32'(rsp_valid),  32'd1);
        checkOutput("add_rsp_id",       32'(rsp_id),     32'd0);
        checkOutput("add_rsp_result",   rsp_result,      32'h0);
        checkOutput("add_rsp_carry",    32'(rsp_carry),  32'd1);
        checkOutput("add_rsp_zero",     32'(rsp_zero),   32'd0);
        checkOutput("add_alu_hold",     alu_src1,        32'hFFFFFFFF);
        tick();
        checkOutput("add_back_idle",    32'(rsp_valid),  32'd0);

        // Zero flag: req1 and of equal operands
        applyStimulus(1, 1'b1, 32'h0000FFFF, 32'h0000FFFF, F_AND, 5'd0);
        #1;
        checkOutput("and_req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("and_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        tick();
        checkOutput("and_rsp_valid",  32'(rsp_valid), 32'd1);
        checkOutput("and_rsp_id",     32'(rsp_id),    32'd1);
        checkOutput("and_rsp_result", rsp_result,     32'h0000FFFF);
        checkOutput("and_rsp_zero",   32'(rsp_zero),  32'd1);
        checkOutput("and_rsp_carry",  32'(rsp_carry), 32'd0);
        tick();

        // Contention: both valid held for four operations, one every three cycles
        applyStimulus(0, 1'b1, 32'd5, 32'd3, F_SUB, 5'd0);
        applyStimulus(1, 1'b1, 32'h80000000, 32'd0, F_SRL, 5'd4);
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("cont%0d_req0_ready", k), 32'(req0_ready), 32'(!exp_grant[k]));
            checkOutput($sformatf("cont%0d_req1_ready", k), 32'(req1_ready), 32'(exp_grant[k]));
            tick();
            checkOutput($sformatf("cont%0d_exec_ready", k), 32'({req0_ready, req1_ready}), 32'd0);
            tick();
            checkOutput($sformatf("cont%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("cont%0d_rsp_id", k), 32'(rsp_id), 32'(exp_grant[k]));
            checkOutput($sformatf("cont%0d_rsp_result", k), rsp_result,
                        exp_grant[k] ? 32'h08000000 : 32'h00000002);
            checkOutput($sformatf("cont%0d_resp_ready", k), 32'({req0_ready, req1_ready}), 32'd0);
            tick();
        end
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        tick();

        // Backpressure: response held five cycles while req1 waits
        rsp_ready = 1'b0;
        applyStimulus(0, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, F_AND, 5'd0);
        tick();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        applyStimulus(1, 1'b1, 32'd2, 32'd3, F_ADD, 5'd0);
        #1;
        checkOutput("bp_exec_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp%0d_rsp_valid", k),  32'(rsp_valid), 32'd1);
            checkOutput($sformatf("bp%0d_rsp_result", k), rsp_result,     32'hF000F000);
            checkOutput($sformatf("bp%0d_rsp_id", k),     32'(rsp_id),    32'd0);
            checkOutput($sformatf("bp%0d_ready", k), 32'({req0_ready, req1_ready}), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("bp_release_valid",   32'(rsp_valid),  32'd0);
        checkOutput("bp_waiter_granted",  32'(req1_ready), 32'd1);
        tick();
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        tick();
        checkOutput("bp_waiter_id",     32'(rsp_id), 32'd1);
        checkOutput("bp_waiter_result", rsp_result,  32'd5);
        tick();

        // Reset during EXEC discards the operation
        applyStimulus(0, 1'b1, 32'd9, 32'd4, F_SUB, 5'd0);
        tick();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_exec_rsp_valid",  32'(rsp_valid), 32'd0);
        checkOutput("rst_exec_rsp_id",     32'(rsp_id),    32'd0);
        checkOutput("rst_exec_rsp_result", rsp_result,     32'd0);
        checkOutput("rst_exec_alu_src1",   alu_src1,       32'd0);
        checkOutput("rst_exec_alu_funct",  32'(alu_funct), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("rst_quiet%0d_valid", k), 32'(rsp_valid), 32'd0);
            tick();
        end

        // First tie after reset goes to req0 in either configuration
        applyStimulus(0, 1'b1, 32'd7, 32'd7, F_SUB, 5'd0);
        applyStimulus(1, 1'b1, 32'd1, 32'd2, F_ADD, 5'd0);
        #1;
        checkOutput("post_rst_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("post_rst_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        tick();
        checkOutput("post_rst_rsp_result", rsp_result,     32'd0);
        checkOutput("post_rst_rsp_zero",   32'(rsp_zero),  32'd1);
        checkOutput("post_rst_rsp_id",     32'(rsp_id),    32'd0);
        tick();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
